// File: rtl/alu_defs.sv
// Shared definitions for the ALU command sequencer:
// Fin function codes, shift-class decode and FSM state encoding.
package alu_defs;

  localparam logic [3:0] FIN_AND  = 4'b0000;
  localparam logic [3:0] FIN_OR   = 4'b0001;
  localparam logic [3:0] FIN_ADD  = 4'b0010;
  localparam logic [3:0] FIN_SAT  = 4'b0011;
  localparam logic [3:0] FIN_XOR  = 4'b0100;
  localparam logic [3:0] FIN_XNOR = 4'b0101;
  localparam logic [3:0] FIN_SUB  = 4'b0110;
  localparam logic [3:0] FIN_SLT  = 4'b0111;
  localparam logic [3:0] FIN_NAND = 4'b1000;
  localparam logic [3:0] FIN_NOR  = 4'b1001;
  localparam logic [3:0] FIN_LSL  = 4'b1010;
  localparam logic [3:0] FIN_LSR  = 4'b1011;
  localparam logic [3:0] FIN_PASS = 4'b1100;
  localparam logic [3:0] FIN_ASR  = 4'b1101;
  localparam logic [3:0] FIN_RL   = 4'b1110;
  localparam logic [3:0] FIN_RR   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } state_e;

  // Single-bit shift/rotate codes that get repeated for shift-by-N.
  function automatic logic is_shift(input logic [3:0] fin);
    return (fin == FIN_LSL) || (fin == FIN_LSR) ||
           (fin == FIN_ASR) || (fin == FIN_RL)  ||
           (fin == FIN_RR);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_fsm.sv
// Control FSM for the ALU sequencer: state, repeat counter, handshakes.
// In: cmd_valid/fin/shamt, res_ready. Out: state, accept, last_iter, cmd_ready, res_valid.
module alu_op_sequencer_fsm
  import alu_defs::*;
#(
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  input  logic [3:0]     cmd_fin,
  input  logic [SHW-1:0] cmd_shamt,
  input  logic           res_ready,
  output state_e         state,
  output logic           accept,
  output logic           last_iter,
  output logic           cmd_ready,
  output logic           res_valid
);

  state_e         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           rv_q, rv_d;

  assign state     = state_q;
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign last_iter = (cnt_q == SHW'(1));
  assign res_valid = rv_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_shift(cmd_fin)) begin
            state_d = EXEC;
          end else if (cmd_shamt == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = cmd_shamt;
            state_d = ITER;
          end
        end
      end
      EXEC: state_d = DONE;
      ITER: begin
        cnt_d = cnt_q - SHW'(1);
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        // res_valid rises one cycle after entering DONE.
        if (rv_q && res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end else begin
          rv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of a sibling 32-bit ALU; repeats shifts.
// cmd_* in, res_* out (valid/ready); alu_a/b/fin drive ALU, alu_y/cout return.
module alu_op_sequencer
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fin,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SHW-1:0]   cmd_shamt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout
);

  state_e           state;
  logic             accept;
  logic             last_iter;

  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;

  alu_op_sequencer_fsm #(
    .SHW(SHW)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_fin   (cmd_fin),
    .cmd_shamt (cmd_shamt),
    .res_ready (res_ready),
    .state     (state),
    .accept    (accept),
    .last_iter (last_iter),
    .cmd_ready (cmd_ready),
    .res_valid (res_valid)
  );

  assign alu_a    = work_q;
  assign alu_b    = opb_q;
  assign alu_fin  = op_q;
  assign res_y    = y_q;
  assign res_cout = cout_q;

  always_comb begin
    op_d   = op_q;
    work_d = work_q;
    opb_d  = opb_q;
    y_d    = y_q;
    cout_d = cout_q;
    case (state)
      IDLE: begin
        if (accept) begin
          work_d = cmd_a;
          opb_d  = cmd_b;
          op_d   = cmd_fin;
          // Zero-length shift bypasses the ALU entirely.
          if (is_shift(cmd_fin) && cmd_shamt == '0) begin
            y_d    = cmd_a;
            cout_d = 1'b0;
          end
        end
      end
      EXEC: begin
        y_d    = alu_y;
        cout_d = alu_cout;
      end
      ITER: begin
        work_d = alu_y;
        if (last_iter) begin
          y_d    = alu_y;
          cout_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      work_q <= '0;
      opb_q  <= '0;
      y_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      work_q <= work_d;
      opb_q  <= opb_d;
      y_q    <= y_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU.
// Covers reset, single-issue, shift-by-N, shift-0, backpressure and abort.
module tb_alu_op_sequencer;
  import alu_defs::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_fin;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [4:0]  cmd_shamt;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_y;
  logic        res_cout;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_fin;
  logic [31:0] alu_y;
  logic        alu_cout;
  logic        corrupt;

  int tests;
  int fails;

  alu_op_sequencer #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_fin   (cmd_fin),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_shamt (cmd_shamt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_cout  (res_cout),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fin   (alu_fin),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the sibling ALU.
  logic [32:0] sum;
  always_comb begin
    sum      = '0;
    alu_y    = '0;
    alu_cout = 1'b0;
    case (alu_fin)
      FIN_AND: alu_y = alu_a & alu_b;
      FIN_OR:  alu_y = alu_a | alu_b;
      FIN_ADD: begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y    = sum[31:0];
        alu_cout = sum[32];
      end
      FIN_SUB: begin
        alu_y    = alu_a - alu_b;
        alu_cout = (alu_a < alu_b);
      end
      FIN_XOR: alu_y = alu_a ^ alu_b;
      FIN_LSL: begin
        alu_y    = {alu_a[30:0], 1'b0};
        alu_cout = alu_a[31];
      end
      FIN_LSR: begin
        alu_y    = {1'b0, alu_a[31:1]};
        alu_cout = alu_a[0];
      end
      FIN_ASR: alu_y = {alu_a[31], alu_a[31:1]};
      FIN_RL:  alu_y = {alu_a[30:0], alu_a[31]};
      FIN_RR:  alu_y = {alu_a[0], alu_a[31:1]};
      default: alu_y = alu_b;
    endcase
    if (corrupt) begin
      alu_y    = 32'h1234_5678;
      alu_cout = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one command, count edges from accept until res_valid.
  task automatic issue(input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       output int lat, output logic fin_ok);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    cmd_valid = 1'b1;
    cmd_fin   = f;
    cmd_a     = a;
    cmd_b     = b;
    cmd_shamt = sh;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a     = 32'hA5A5_A5A5;
    cmd_fin   = FIN_AND;
    lat       = 0;
    fin_ok    = 1'b1;
    while (!res_valid && lat < 100) begin
      if (alu_fin !== f) fin_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (alu_fin !== f) fin_ok = 1'b0;
  endtask

  task automatic take;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  int   lat;
  logic fin_ok;
  logic hold_ok;
  logic quiet;

  initial begin
    tests     = 0;
    fails     = 0;
    corrupt   = 1'b0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_fin   = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_shamt = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outs", {res_y ^ alu_a ^ alu_b, 28'd0, alu_fin} |
                    {31'd0, res_cout}, 0);
    rst_n = 1'b1;

    // ADD with carry out
    issue(FIN_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, fin_ok);
    chk("add_lat", lat, 2);
    chk("add_y", res_y, 32'h0);
    chk("add_cout", res_cout, 1);
    take();
    chk("add_post_valid", res_valid, 0);
    chk("add_post_ready", cmd_ready, 1);

    // LSL by 31
    issue(FIN_LSL, 32'h1, 32'h0, 5'd31, lat, fin_ok);
    chk("lsl31_lat", lat, 32);
    chk("lsl31_y", res_y, 32'h8000_0000);
    chk("lsl31_cout", res_cout, 0);
    chk("lsl31_fin", fin_ok, 1);
    take();

    // RR by 4
    issue(FIN_RR, 32'h1, 32'h0, 5'd4, lat, fin_ok);
    chk("rr4_lat", lat, 5);
    chk("rr4_y", res_y, 32'h1000_0000);
    take();

    // RL by 1
    issue(FIN_RL, 32'h8000_0000, 32'h0, 5'd1, lat, fin_ok);
    chk("rl1_lat", lat, 2);
    chk("rl1_y", res_y, 32'h1);
    take();

    // LSL by 0 bypasses the ALU
    corrupt = 1'b1;
    issue(FIN_LSL, 32'hDEAD_BEEF, 32'h0, 5'd0, lat, fin_ok);
    chk("lsl0_lat", lat, 1);
    chk("lsl0_y", res_y, 32'hDEAD_BEEF);
    chk("lsl0_cout", res_cout, 0);
    take();
    corrupt = 1'b0;

    // SUB with result backpressure and a queued command
    issue(FIN_SUB, 32'd5, 32'd7, 5'd0, lat, fin_ok);
    chk("sub_lat", lat, 2);
    cmd_valid = 1'b1;
    cmd_fin   = FIN_ADD;
    cmd_a     = 32'd1;
    cmd_b     = 32'd2;
    cmd_shamt = 5'd0;
    hold_ok   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (res_y !== 32'hFFFF_FFFE || res_cout !== 1'b1 ||
          cmd_ready !== 1'b0 || res_valid !== 1'b1) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("sub_hold", hold_ok, 1);
    chk("sub_y", res_y, 32'hFFFF_FFFE);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("hs_idle_ready", cmd_ready, 1);
    chk("hs_valid_low", res_valid, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("next_accepted", cmd_ready, 0);
    chk("next_alu_a", alu_a, 32'd1);
    chk("next_alu_b", alu_b, 32'd2);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("next_y", res_y, 32'd3);
    take();

    // Reset during ITER aborts the command
    cmd_valid = 1'b1;
    cmd_fin   = FIN_LSR;
    cmd_a     = 32'hFFFF_FFFF;
    cmd_b     = 32'h0;
    cmd_shamt = 5'd20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("iter_busy", cmd_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_valid", res_valid, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_fin", alu_fin, 0);
    chk("abort_res", {res_y[30:0], res_cout} | alu_b, 0);
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
      @(posedge clk); #1;
    end
    chk("abort_quiet", quiet, 1);

    // Recovery after abort
    issue(FIN_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd3, lat, fin_ok);
    chk("xor_lat", lat, 2);
    chk("xor_y", res_y, 32'h0F0F_F0F0);
    take();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-level controller in front of the shared 32-bit ALU (4-bit Fin function select).
- Accepts one ALU command at a time over a valid/ready handshake and drives the ALU operand/function ports.
- Single-bit shift/rotate functions are repeated to build shift-by-N operations; all other functions are issued once.
- Returns the result over a valid/ready handshake. The ALU is instantiated beside this block, not inside it.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block idle; command accepted when cmd_valid & cmd_ready
- cmd_fin  input  4  ALU function code
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- cmd_shamt  input  SHW  repeat count; used only for shift-class functions
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_y  output  WIDTH  result
- res_cout  output  1  carry/flag from the ALU
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_fin  output  4  to ALU Fin
- alu_y  input  WIDTH  from ALU Y
- alu_cout  input  1  from ALU Cout

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all registers zero. Outputs after reset: res_valid=0, res_y=0, res_cout=0, alu_a=0, alu_b=0, alu_fin=0000, cmd_ready=1. Reset mid-operation aborts the command with no result; the next edge with rst_n high starts from IDLE.
- Shift class: Fin 1010 LSL, 1011 LSR, 1101 ASR, 1110 RL, 1111 RR. All other codes, including 0011, are single-issue.
- Registers: op (4b), work (WIDTH), opb (WIDTH), cnt (SHW), y_r, cout_r.
- ALU drive: alu_a=work, alu_b=opb, alu_fin=op in every state (registered).
- States:
  - IDLE:
    - cmd_ready=1.
    - On accept, capture work=cmd_a, opb=cmd_b, op=cmd_fin.
    - Shift class with shamt=0: y_r=cmd_a, cout_r=0, go to DONE. The ALU is not used.
    - Shift class with shamt≠0: cnt=shamt, go to ITER.
    - Otherwise: go to EXEC.
  - EXEC: one cycle. y_r=alu_y, cout_r=alu_cout, go to DONE.
  - ITER:
    - Each cycle: work=alu_y, cnt=cnt-1.
    - When cnt=1: y_r=alu_y, cout_r=0, go to DONE.
    - A shamt of 31 gives 31 ITER cycles.
  - DONE:
    - res_valid=1; res_y/res_cout held stable until res_ready=1.
    - On res_valid & res_ready, go to IDLE.
- cmd_ready=0 in EXEC, ITER and DONE. No overlap: the next accept is at the earliest the cycle after the result handshake.
- Latency, with accept at edge t:
  - single-issue: res_valid high after edge t+2
  - shift N≥1: after edge t+1+N
  - shift 0: after edge t+1
- Result semantics are exactly those of the ALU, including SLT, SAT, XOR/XNOR cout. No width extension or masking is added.
- Simultaneous res_ready and cmd_valid in DONE: the result completes; the command is not accepted that cycle.
- cmd_* inputs are ignored when not accepted.

Decomposition:
- Shared package alu_defs holds:
  - Fin code constants (AND..RR)
  - shift-class decode function is_shift(fin)
  - state encoding IDLE=00, EXEC=01, ITER=10, DONE=11
- One natural sub-module: alu_op_sequencer_fsm (state register, cnt, handshake flags). The datapath registers stay in the top.
- The ALU is a sibling instance connected by the integrator.

Test Plan:
- ADD (0010) A=FFFFFFFF B=00000001 -> res_y=00000000, res_cout=1, res_valid 2 cycles after accept.
- LSL (1010) A=00000001 shamt=31 -> res_y=80000000, res_cout=0, res_valid 32 cycles after accept; alu_fin=1010 throughout.
- RR (1111) A=00000001 shamt=4 -> res_y=10000000; RL A=80000000 shamt=1 -> res_y=00000001, res_valid after 2 cycles.
- LSL A=DEADBEEF shamt=0 -> res_y=DEADBEEF, res_cout=0, res_valid 1 cycle after accept; alu_y changes have no effect.
- SUB A=5 B=7 with res_ready low 5 cycles -> res_y=FFFFFFFE and res_cout=1 stable for all 5 cycles, cmd_ready=0 throughout. The next command, offered concurrently, is accepted only after the handshake.
- Reset: rst_n low for one edge during ITER (LSR shamt=20, cycle 8) -> next cycle res_valid=0, cmd_ready=1, all outputs 0, no result emitted.
